// File: rtl/score_keeper.sv
// score_keeper: saturating score counter, per-frame snapshot and iterative binary-to-BCD conversion.
// Optional SCORE_HIGH_SCORE_EN keeps a best-score register alongside the live count.
module score_keeper #(
  parameter int MAX_SCORE = 999,
  parameter int POINTS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        game_rst,
  input  logic        eat,
  input  logic        frame_start,
  output logic [9:0]  score,
  output logic [11:0] score_bcd,
  output logic        bcd_busy,
  output logic [9:0]  high_score
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [10:0] MAX = 11'(MAX_SCORE);
  state_t state, state_nx;
  logic [9:0] cnt;
  logic [10:0] sum;
  logic [21:0] sr, sr_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [11:0] bcd_nx;
  logic pend, pend_nx, busy_nx, take;
  function automatic logic [21:0] dabble(input logic [21:0] v);
    logic [21:0] t;
    t = v;
    for (int k = 0; k < 3; k++)
      if (t[10+4*k +: 4] >= 4'd5) t[10+4*k +: 4] = t[10+4*k +: 4] + 4'd3;
    return {t[20:0], 1'b0};
  endfunction
  assign sum = {1'b0, cnt} + 11'(POINTS);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (game_rst) cnt <= '0;
    else if (eat) cnt <= (sum > MAX) ? MAX[9:0] : sum[9:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) score <= '0;
    else if (frame_start) score <= cnt;
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    bit_cnt_nx = bit_cnt;
    bcd_nx = score_bcd;
    busy_nx = bcd_busy;
    take = 1'b0;
    case (state)
      IDLE: if (pend) begin
        state_nx = SHIFT;
        sr_nx = {12'b0, score};
        bit_cnt_nx = 4'd0;
        busy_nx = 1'b1;
        take = 1'b1;
      end
      SHIFT: begin
        sr_nx = dabble(sr);
        bit_cnt_nx = bit_cnt + 4'd1;
        state_nx = (bit_cnt == 4'd9) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_nx = sr[21:10];
        // Back-to-back request: BCD nibbles start at zero, so the first shift is folded into the load.
        state_nx = pend ? SHIFT : IDLE;
        sr_nx = pend ? {11'b0, score, 1'b0} : sr;
        bit_cnt_nx = pend ? 4'd1 : bit_cnt;
        busy_nx = pend;
        take = pend;
      end
      default: state_nx = IDLE;
    endcase
    pend_nx = frame_start | (pend & ~take);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      score_bcd <= '0;
      bcd_busy <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      bit_cnt <= bit_cnt_nx;
      score_bcd <= bcd_nx;
      bcd_busy <= busy_nx;
      pend <= pend_nx;
    end
`ifdef SCORE_HIGH_SCORE_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) high_score <= '0;
    else if ((game_rst | frame_start) && cnt > high_score) high_score <= cnt;
`else
  assign high_score = '0;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table vectors, corner sequences and a randomized model check on three score_keeper configurations.
module tb_score_keeper;
  logic clk = 0, reset_n = 0, game_rst = 0, eat = 0, frame_start = 0;
  logic [2:0][9:0] sc, hs;
  logic [2:0][11:0] bcd;
  logic [2:0] busy;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  score_keeper #(.MAX_SCORE(999), .POINTS(1)) u0 (.clk(clk), .reset_n(reset_n), .game_rst(game_rst), .eat(eat),
    .frame_start(frame_start), .score(sc[0]), .score_bcd(bcd[0]), .bcd_busy(busy[0]), .high_score(hs[0]));
  score_keeper #(.MAX_SCORE(999), .POINTS(9)) u1 (.clk(clk), .reset_n(reset_n), .game_rst(game_rst), .eat(eat),
    .frame_start(frame_start), .score(sc[1]), .score_bcd(bcd[1]), .bcd_busy(busy[1]), .high_score(hs[1]));
  score_keeper #(.MAX_SCORE(20), .POINTS(7)) u2 (.clk(clk), .reset_n(reset_n), .game_rst(game_rst), .eat(eat),
    .frame_start(frame_start), .score(sc[2]), .score_bcd(bcd[2]), .bcd_busy(busy[2]), .high_score(hs[2]));
  function automatic int pts_of(input int i);
    return i == 0 ? 1 : i == 1 ? 9 : 7;
  endfunction
  function automatic int max_of(input int i);
    return i == 2 ? 20 : 999;
  endfunction
  function automatic int to_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction
  function automatic int hs_exp(input int v);
`ifdef SCORE_HIGH_SCORE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction
  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got 0x%0h want 0x%0h at cycle %0d", name, i, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic pulse_eats(input int n);
    for (int k = 0; k < n; k++) begin
      eat = 1;
      tick();
    end
    eat = 0;
  endtask
  task automatic clear_game();
    game_rst = 1;
    tick();
    game_rst = 0;
  endtask
  task automatic chk_all(input string name, input int kind, input int e0, input int e1, input int e2);
    int e[3];
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++)
      case (kind)
        0: chk(name, i, int'(sc[i]), e[i]);
        1: chk(name, i, int'(bcd[i]), to_bcd(e[i]));
        2: chk(name, i, int'(busy[i]), e[i]);
        default: chk(name, i, int'(hs[i]), hs_exp(e[i]));
      endcase
  endtask
  task automatic frame_and_check(input string tag, input int e0, input int e1, input int e2);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk_all({tag, "_score"}, 0, e0, e1, e2);
    tick();
    chk_all({tag, "_busy_rise"}, 2, 1, 1, 1);
    repeat (10) tick();
    chk_all({tag, "_busy_hold"}, 2, 1, 1, 1);
    tick();
    chk_all({tag, "_bcd"}, 1, e0, e1, e2);
    chk_all({tag, "_busy_fall"}, 2, 0, 0, 0);
  endtask
  typedef struct {
    int n_eat;
    int s0, s1, s2;
  } vec_t;
  vec_t tbl[6];
  int m_cnt[3], m_sc[3], m_hs[3], m_bcd[3];
  int t0;
  logic e, g, f;
  initial begin
    tbl[0] = '{5, 5, 45, 20};
    tbl[1] = '{0, 0, 0, 0};
    tbl[2] = '{100, 100, 900, 20};
    tbl[3] = '{111, 111, 999, 20};
    tbl[4] = '{4, 4, 36, 20};
    tbl[5] = '{2, 2, 18, 14};
    repeat (3) tick();
    chk_all("rst_score", 0, 0, 0, 0);
    chk_all("rst_bcd", 1, 0, 0, 0);
    chk_all("rst_busy", 2, 0, 0, 0);
    chk_all("rst_hs", 3, 0, 0, 0);
    reset_n = 1;
    tick();
    foreach (tbl[v]) begin
      clear_game();
      pulse_eats(tbl[v].n_eat);
      frame_and_check($sformatf("vec%0d", v), tbl[v].s0, tbl[v].s1, tbl[v].s2);
    end
    clear_game();
    pulse_eats(5);
    eat = 1;
    game_rst = 1;
    tick();
    eat = 0;
    game_rst = 0;
    frame_and_check("eat_and_rst", 0, 0, 0);
    clear_game();
    pulse_eats(3);
    eat = 1;
    frame_start = 1;
    tick();
    eat = 0;
    frame_start = 0;
    chk_all("eat_and_frame", 0, 3, 27, 20);
    repeat (12) tick();
    frame_and_check("eat_shown_next", 4, 36, 20);
    clear_game();
    pulse_eats(12);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk_all("ovl_score1", 0, 12, 108, 20);
    tick();
    eat = 1;
    tick();
    eat = 0;
    tick();
    frame_start = 1;
    tick();
    frame_start = 0;
    chk_all("ovl_score2", 0, 13, 117, 20);
    repeat (7) tick();
    chk_all("ovl_busy1", 2, 1, 1, 1);
    tick();
    chk_all("ovl_bcd1", 1, 12, 108, 20);
    chk_all("ovl_busy_cont", 2, 1, 1, 1);
    repeat (9) tick();
    chk_all("ovl_busy2", 2, 1, 1, 1);
    chk_all("ovl_bcd_hold", 1, 12, 108, 20);
    tick();
    chk_all("ovl_bcd2", 1, 13, 117, 20);
    chk_all("ovl_done", 2, 0, 0, 0);
    reset_n = 0;
    tick();
    reset_n = 1;
    pulse_eats(42);
    game_rst = 1;
    tick();
    game_rst = 0;
    chk_all("hs_after_rst", 3, 42, 378, 20);
    pulse_eats(17);
    frame_and_check("hs_lower", 17, 153, 20);
    chk_all("hs_kept", 3, 42, 378, 20);
    frame_start = 1;
    tick();
    frame_start = 0;
    repeat (5) tick();
    #2 reset_n = 0;
    #1;
    chk_all("async_rst_score", 0, 0, 0, 0);
    chk_all("async_rst_bcd", 1, 0, 0, 0);
    chk_all("async_rst_busy", 2, 0, 0, 0);
    chk_all("async_rst_hs", 3, 0, 0, 0);
    tick();
    reset_n = 1;
    repeat (20) tick();
    chk_all("no_resume_busy", 2, 0, 0, 0);
    chk_all("no_resume_bcd", 1, 0, 0, 0);
    m_cnt = '{0, 0, 0};
    m_sc = '{0, 0, 0};
    m_hs = '{0, 0, 0};
    m_bcd = '{0, 0, 0};
    t0 = -100;
    for (int n = 0; n < 800; n++) begin
      e = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 39) == 0);
      f = (cyc + 1 - t0 >= 14) && ($urandom_range(0, 7) == 0);
      eat = e;
      game_rst = g;
      frame_start = f;
      tick();
      if (f) t0 = cyc;
      for (int i = 0; i < 3; i++) begin
        if ((f || g) && m_cnt[i] > m_hs[i]) m_hs[i] = m_cnt[i];
        if (f) m_sc[i] = m_cnt[i];
        if (g) m_cnt[i] = 0;
        else if (e) m_cnt[i] = (m_cnt[i] + pts_of(i) > max_of(i)) ? max_of(i) : m_cnt[i] + pts_of(i);
        if (cyc == t0 + 12) m_bcd[i] = to_bcd(m_sc[i]);
        chk("rnd_score", i, int'(sc[i]), m_sc[i]);
        chk("rnd_bcd", i, int'(bcd[i]), m_bcd[i]);
        chk("rnd_busy", i, int'(busy[i]), int'(cyc >= t0 + 1 && cyc <= t0 + 11));
        chk("rnd_hs", i, int'(hs[i]), hs_exp(m_hs[i]));
      end
    end
    eat = 0;
    game_rst = 0;
    frame_start = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
